// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: debug-transport side controller for DMI accesses.
// A 41-bit scan word {addr, data, op} launches a read or write on the DMI
// request channel, waits for the response, and reports a sticky status
// through the captured scan word and error_o.
// Optional feature: define DMI_RESP_TIMEOUT_EN to abort a response wait
// after TimeoutCycles cycles with a failed status.
//
// Handshake: a channel transfers on a rising clk_i edge where valid and
// ready are both high; dmi_req_o is held constant while dmi_req_valid_o
// is high, and dmi_req_valid_o never drops before the transfer except on
// dmihardreset_i or rst_i.

package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_access_ctrl #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          update_i,
    input  logic [40:0]   dr_i,
    input  logic          capture_i,
    output logic [40:0]   dr_o,
    input  logic          dmireset_i,
    input  logic          dmihardreset_i,
    output logic [1:0]    error_o,
    output logic          busy_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    output dm::dmi_req_t  dmi_req_o,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o,
    input  dm::dmi_resp_t dmi_resp_i
);

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] ErrOk     = 2'd0;
    localparam logic [1:0] ErrFailed = 2'd2;
    localparam logic [1:0] ErrBusy   = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ_READ   = 3'd1,
        WAIT_READ  = 3'd2,
        REQ_WRITE  = 3'd3,
        WAIT_WRITE = 3'd4
    } state_e;

    // The response-wait limit must fit the 16-bit wait counter.
    if ((TimeoutCycles < 1) || (TimeoutCycles > 65535)) begin : g_timeout_range
        $error("dmi_access_ctrl: TimeoutCycles must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  error_q, error_d;
    logic [40:0] dr_q, dr_d;

    logic [6:0]  scan_addr;
    logic [31:0] scan_data;
    logic [1:0]  scan_op;
    logic        busy;
    logic        waiting;
    logic        resp_fire;
    logic        timeout_hit;

    assign scan_addr = dr_i[40:34];
    assign scan_data = dr_i[33:2];
    assign scan_op   = dr_i[1:0];

    assign busy      = (state_q != IDLE);
    assign waiting   = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);
    assign resp_fire = waiting && dmi_resp_valid_i;

`ifdef DMI_RESP_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    // Counts cycles spent waiting for a response; zero in every other state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= waiting ? (wait_cnt_q + 16'd1) : 16'd0;
        end
    end

    // A response arriving in the last allowed cycle still wins over the abort.
    assign timeout_hit = waiting && !dmi_resp_valid_i &&
                         (wait_cnt_q == 16'(TimeoutCycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= 7'd0;
            data_q  <= 32'd0;
            error_q <= ErrOk;
            dr_q    <= 41'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
            dr_q    <= dr_d;
        end
    end

    // Next-state, sticky-status and capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;
        dr_d    = dr_q;

        case (state_q)
            IDLE: begin
                // A pending error blocks new accesses until it is cleared.
                if (update_i && (error_q == ErrOk)) begin
                    if (scan_op == OpRead) begin
                        state_d = REQ_READ;
                        addr_d  = scan_addr;
                    end else if (scan_op == OpWrite) begin
                        state_d = REQ_WRITE;
                        addr_d  = scan_addr;
                        data_d  = scan_data;
                    end
                end
            end
            REQ_READ: begin
                if (dmi_req_ready_i) state_d = WAIT_READ;
            end
            REQ_WRITE: begin
                if (dmi_req_ready_i) state_d = WAIT_WRITE;
            end
            WAIT_READ: begin
                if (dmi_resp_valid_i) begin
                    data_d  = dmi_resp_i.data;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_WRITE: begin
                if (dmi_resp_valid_i || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The first error recorded is kept; later ones never replace it.
        if (error_q == ErrOk) begin
            if (busy && (update_i || capture_i)) begin
                error_d = ErrBusy;
            end else if (resp_fire && (dmi_resp_i.resp != 2'd0)) begin
                error_d = ErrFailed;
            end else if (timeout_hit) begin
                error_d = ErrFailed;
            end
        end

        if (capture_i) begin
            dr_d = {addr_q, data_q, busy ? ErrBusy : error_q};
        end

        if (dmireset_i) error_d = ErrOk;

        // Hard reset abandons the access but keeps the last address and data.
        if (dmihardreset_i) begin
            state_d = IDLE;
            error_d = ErrOk;
            addr_d  = addr_q;
            data_d  = data_q;
        end
    end

    // Request word is built only from registers, so it is stable while valid.
    always_comb begin
        dmi_req_o      = '0;
        dmi_req_o.addr = addr_q;
        dmi_req_o.op   = (state_q == REQ_WRITE) ? OpWrite : OpRead;
        dmi_req_o.data = (state_q == REQ_WRITE) ? data_q : 32'd0;
    end

    assign dmi_req_valid_o  = (state_q == REQ_READ) || (state_q == REQ_WRITE);
    assign dmi_resp_ready_o = waiting;
    assign busy_o           = busy;
    assign error_o          = error_q;
    assign dr_o             = dr_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Testbench for dmi_access_ctrl: table-driven op decode, directed
// multi-cycle sequences and randomized traffic against a transaction-level
// reference model.

module tb_dmi_access_ctrl;

    localparam int TO = 4;
`ifdef DMI_RESP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          update_i;
    logic [40:0]   dr_i;
    logic          capture_i;
    logic [40:0]   dr_o;
    logic          dmireset_i;
    logic          dmihardreset_i;
    logic [1:0]    error_o;
    logic          busy_o;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    dm::dmi_req_t  dmi_req_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    dm::dmi_resp_t dmi_resp_i;

    always #5 clk_i = ~clk_i;

    dmi_access_ctrl #(.TimeoutCycles(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .dr_i             (dr_i),
        .capture_i        (capture_i),
        .dr_o             (dr_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .error_o          (error_o),
        .busy_o           (busy_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // One access at a time: phase 0 = none, 1 = being offered, 2 = awaiting answer.
    int          m_phase;
    bit          m_write;
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_err;
    logic [40:0] m_dr;
    int          m_waited;
    logic [40:0] exp_q[$];   // request words the bus should accept, in order

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_err    = '0;
        m_dr     = '0;
        m_waited = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit         was_busy;
        bit         expired;
        logic [1:0] e;
        logic [1:0] op;
        was_busy = (m_phase != 0);
        op       = dr_i[1:0];
        expired  = TO_EN && (m_phase == 2) && !dmi_resp_valid_i && (m_waited + 1 == TO);
        e        = m_err;
        if (m_err == 2'd0) begin
            if (was_busy && (update_i || capture_i))                        e = 2'd3;
            else if (m_phase == 2 && dmi_resp_valid_i && dmi_resp_i.resp != 2'd0) e = 2'd2;
            else if (expired)                                               e = 2'd2;
        end
        if (dmireset_i || dmihardreset_i) e = 2'd0;
        if (capture_i) m_dr = {m_addr, m_data, was_busy ? 2'd3 : m_err};
        if (m_phase == 1 && dmi_req_ready_i)
            exp_q.push_back({m_addr, m_write ? 2'd2 : 2'd1, m_write ? m_data : 32'd0});
        if (dmihardreset_i) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (update_i && m_err == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
                m_phase = 1;
                m_write = (op == 2'd2);
                m_addr  = dr_i[40:34];
                if (m_write) m_data = dr_i[33:2];
            end
        end else if (m_phase == 1) begin
            if (dmi_req_ready_i) begin
                m_phase  = 2;
                m_waited = 0;
            end
        end else begin
            if (dmi_resp_valid_i) begin
                if (!m_write) m_data = dmi_resp_i.data;
                m_phase = 0;
            end else begin
                m_waited++;
                if (expired) m_phase = 0;
            end
        end
        m_err = e;
    endtask

    task automatic check_outputs();
        chk("busy", 64'(busy_o), 64'(m_phase != 0));
        chk("req_valid", 64'(dmi_req_valid_o), 64'(m_phase == 1));
        chk("resp_ready", 64'(dmi_resp_ready_o), 64'(m_phase == 2));
        chk("error", 64'(error_o), 64'(m_err));
        chk("dr_o", 64'(dr_o), 64'(m_dr));
        if (m_phase == 1)
            chk("req_word", 64'(dmi_req_o),
                64'({m_addr, m_write ? 2'd2 : 2'd1, m_write ? m_data : 32'd0}));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already driven; returns at the next
    // falling edge after checking outputs, with one-cycle pulses cleared.
    task automatic step();
        model_update();
        if (dmi_req_valid_o && dmi_req_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_accept: unexpected request 0x%0h at %0t", dmi_req_o, $time);
            end else begin
                chk("req_accept", 64'(dmi_req_o), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
        update_i       = 1'b0;
        capture_i      = 1'b0;
        dmireset_i     = 1'b0;
        dmihardreset_i = 1'b0;
    endtask

    task automatic clean_idle();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmihardreset_i   = 1'b1;
        step();
    endtask

    // Leaves the DUT idle with status 3 (scan update while an access runs).
    task automatic force_error();
        dmi_req_ready_i = 1'b0;
        update_i = 1'b1; dr_i = {7'h01, 32'h0, 2'd1}; step();
        update_i = 1'b1; dr_i = {7'h02, 32'h0, 2'd1}; step();
        dmi_req_ready_i = 1'b1; step();
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0000_0077; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        bit          err_pre;
        bit          exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'd0, 7'h03, 32'h0000_0001, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{2'd1, 7'h7F, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{2'd2, 7'h00, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001};
        vecs[3] = '{2'd3, 7'h15, 32'h1234_0000, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{2'd2, 7'h2A, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{2'd1, 7'h2B, 32'h0,         1'b1, 1'b0, 32'h0};

        rst_i = 1'b1;
        update_i = 1'b0; dr_i = '0; capture_i = 1'b0;
        dmireset_i = 1'b0; dmihardreset_i = 1'b0;
        dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
        model_reset();
        #2;
        chk("rst_dr_o", 64'(dr_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // ---- table: op decode and error gating in IDLE ----
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].err_pre) force_error();
            else begin dmireset_i = 1'b1; step(); end
            chk("vec_err_pre", 64'(error_o), vecs[i].err_pre ? 64'd3 : 64'd0);
            dmi_req_ready_i = 1'b0;
            update_i = 1'b1; dr_i = {vecs[i].addr, vecs[i].data, vecs[i].op}; step();
            chk($sformatf("vec%0d_valid", i), 64'(dmi_req_valid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_op", i), 64'(dmi_req_o.op), 64'(vecs[i].op));
                chk($sformatf("vec%0d_addr", i), 64'(dmi_req_o.addr), 64'(vecs[i].addr));
                chk($sformatf("vec%0d_data", i), 64'(dmi_req_o.data), 64'(vecs[i].exp_data));
            end
            clean_idle();
        end

        // ---- write, accepted immediately, ok response ----
        dmi_req_ready_i = 1'b1;
        update_i = 1'b1; dr_i = {7'h10, 32'hA5A5_0001, 2'd2}; step();
        chk("wr_valid_1cyc", 64'(dmi_req_valid_o), 64'd1);
        chk("wr_op", 64'(dmi_req_o.op), 64'd2);
        chk("wr_addr", 64'(dmi_req_o.addr), 64'h10);
        chk("wr_data", 64'(dmi_req_o.data), 64'hA5A5_0001);
        step();
        chk("wr_wait_ready", 64'(dmi_resp_ready_o), 64'd1);
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        chk("wr_done_busy", 64'(busy_o), 64'd0);
        chk("wr_done_err", 64'(error_o), 64'd0);

        // ---- read returning data, then capture ----
        update_i = 1'b1; dr_i = {7'h11, 32'h0, 2'd1}; step();
        step();
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h1234_5678; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        capture_i = 1'b1; step();
        chk("rd_capture", 64'(dr_o), 64'({7'h11, 32'h1234_5678, 2'd0}));

        // ---- update and capture during a read wait ----
        update_i = 1'b1; dr_i = {7'h05, 32'h0, 2'd1}; step();
        step();
        dmi_req_ready_i = 1'b0;
        chk("busy_wait_ready", 64'(dmi_resp_ready_o), 64'd1);
        update_i = 1'b1; dr_i = {7'h06, 32'hFFFF_0000, 2'd2}; step();
        chk("busy_upd_err", 64'(error_o), 64'd3);
        chk("busy_upd_novalid", 64'(dmi_req_valid_o), 64'd0);
        step();
        chk("busy_upd_novalid2", 64'(dmi_req_valid_o), 64'd0);
        capture_i = 1'b1; step();
        chk("busy_cap_status", 64'(dr_o[1:0]), 64'd3);
        chk("busy_cap_addr", 64'(dr_o[40:34]), 64'h05);
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0000_00AA; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        chk("busy_done_idle", 64'(busy_o), 64'd0);
        chk("busy_err_sticky", 64'(error_o), 64'd3);
        step();
        chk("busy_no_second_req", 64'(dmi_req_valid_o), 64'd0);
        dmireset_i = 1'b1; step();
        chk("dmireset_clears", 64'(error_o), 64'd0);

        // ---- failed read response blocks the next update ----
        dmi_req_ready_i = 1'b1;
        update_i = 1'b1; dr_i = {7'h22, 32'h0, 2'd1}; step();
        step();
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0000_0055; dmi_resp_i.resp = 2'd2; step();
        dmi_resp_valid_i = 1'b0;
        chk("resp_fail_err", 64'(error_o), 64'd2);
        update_i = 1'b1; dr_i = {7'h23, 32'h1, 2'd2}; step();
        chk("resp_fail_blocked", 64'(dmi_req_valid_o), 64'd0);
        chk("resp_fail_idle", 64'(busy_o), 64'd0);
        step();
        chk("resp_fail_blocked2", 64'(dmi_req_valid_o), 64'd0);
        dmireset_i = 1'b1; step();

        // ---- hard reset while a write is stalled ----
        dmi_req_ready_i = 1'b0;
        update_i = 1'b1; dr_i = {7'h33, 32'hCAFE_0000, 2'd2}; step();
        chk("hr_valid", 64'(dmi_req_valid_o), 64'd1);
        capture_i = 1'b1; step();
        chk("hr_valid_held", 64'(dmi_req_valid_o), 64'd1);
        chk("hr_data_held", 64'(dmi_req_o.data), 64'hCAFE_0000);
        chk("hr_err_before", 64'(error_o), 64'd3);
        dmihardreset_i = 1'b1; step();
        chk("hr_valid_drop", 64'(dmi_req_valid_o), 64'd0);
        chk("hr_idle", 64'(busy_o), 64'd0);
        chk("hr_err_clear", 64'(error_o), 64'd0);
        capture_i = 1'b1; step();
        chk("hr_data_kept", 64'(dr_o[33:2]), 64'hCAFE_0000);

        // ---- response wait limit ----
        dmi_req_ready_i = 1'b1;
        update_i = 1'b1; dr_i = {7'h02, 32'h0000_1111, 2'd2}; step();
        step();
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        update_i = 1'b1; dr_i = {7'h03, 32'h0, 2'd1}; step();
        step();
        dmi_req_ready_i = 1'b0;
`ifdef DMI_RESP_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("tmo_still_waiting", 64'(busy_o), 64'd1);
        step();
        chk("tmo_idle", 64'(busy_o), 64'd0);
        chk("tmo_err", 64'(error_o), 64'd2);
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'hDEAD_BEEF; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        capture_i = 1'b1; step();
        chk("tmo_late_data", 64'(dr_o[33:2]), 64'h0000_1111);
        chk("tmo_late_status", 64'(dr_o[1:0]), 64'd2);
        dmireset_i = 1'b1; step();
`else
        repeat (20) step();
        chk("nolimit_waiting", 64'(busy_o), 64'd1);
        chk("nolimit_ready", 64'(dmi_resp_ready_o), 64'd1);
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'h0000_2222; dmi_resp_i.resp = 2'd0; step();
        dmi_resp_valid_i = 1'b0;
        chk("nolimit_done", 64'(busy_o), 64'd0);
`endif

        // ---- reset in the middle of an access ----
        dmi_req_ready_i = 1'b1;
        update_i = 1'b1; dr_i = {7'h44, 32'h0, 2'd1}; step();
        step();
        dmi_req_ready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("mid_rst_dr", 64'(dr_o), 64'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        dmi_resp_valid_i = 1'b1; dmi_resp_i.data = 32'hBEEF_0000; dmi_resp_i.resp = 2'd2; step();
        dmi_resp_valid_i = 1'b0;
        chk("post_rst_idle", 64'(busy_o), 64'd0);
        capture_i = 1'b1; step();
        chk("post_rst_dropped", 64'(dr_o), 64'd0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 800; n++) begin
            update_i         = ($urandom_range(0, 5) == 0);
            dr_i             = {7'($urandom), 32'($urandom), 2'($urandom)};
            capture_i        = ($urandom_range(0, 7) == 0);
            dmireset_i       = ($urandom_range(0, 15) == 0);
            dmihardreset_i   = ($urandom_range(0, 39) == 0);
            dmi_req_ready_i  = 1'($urandom_range(0, 1));
            dmi_resp_valid_i = ($urandom_range(0, 2) == 0);
            dmi_resp_i.data  = 32'($urandom);
            dmi_resp_i.resp  = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0;
            step();
        end

        clean_idle();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
